// File: rtl/med3x3_seq.sv
// 3x3 median filter, sequenced over a shared external 3-input median unit:
// three row medians, then the median of those, one unit evaluation per cycle.
module med3x3_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [9*WIDTH-1:0] in_win,
  output logic [WIDTH-1:0]   m_p1,
  output logic [WIDTH-1:0]   m_p2,
  output logic [WIDTH-1:0]   m_p3,
  input  logic [WIDTH-1:0]   m_med,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_med,
  output logic               busy,
  output logic [15:0]        win_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ROW0  = 3'd1,
    ROW1  = 3'd2,
    ROW2  = 3'd3,
    FINAL = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [9*WIDTH-1:0] win_q, win_d;
  logic [WIDTH-1:0]   rm0_q, rm0_d;
  logic [WIDTH-1:0]   rm1_q, rm1_d;
  logic [WIDTH-1:0]   rm2_q, rm2_d;
  logic [WIDTH-1:0]   out_med_q, out_med_d;
  logic [15:0]        win_cnt_q, win_cnt_d;
  logic [WIDTH-1:0]   m_p1_q, m_p1_d;
  logic [WIDTH-1:0]   m_p2_q, m_p2_d;
  logic [WIDTH-1:0]   m_p3_q, m_p3_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               out_valid_q, out_valid_d;

  function automatic logic [WIDTH-1:0] pix(input logic [9*WIDTH-1:0] w, input int k);
    return w[WIDTH*k +: WIDTH];
  endfunction

  // The window buffer is written only on the IDLE handshake, so it is frozen
  // for the whole evaluation regardless of what in_win does meanwhile.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    rm0_d     = rm0_q;
    rm1_d     = rm1_q;
    rm2_d     = rm2_q;
    out_med_d = out_med_q;
    win_cnt_d = win_cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          win_d   = in_win;
          state_d = ROW0;
        end
      end
      ROW0: begin
        rm0_d   = m_med;
        state_d = ROW1;
      end
      ROW1: begin
        rm1_d   = m_med;
        state_d = ROW2;
      end
      ROW2: begin
        rm2_d   = m_med;
        state_d = FINAL;
      end
      FINAL: begin
        out_med_d = m_med;
        state_d   = DONE;
      end
      DONE: begin
        if (out_ready) begin
          win_cnt_d = win_cnt_q + 16'd1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered: decode the next state and next buffer contents so
  // the operands are already on the flops when the new state begins.
  always_comb begin
    m_p1_d      = '0;
    m_p2_d      = '0;
    m_p3_d      = '0;
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == DONE);
    case (state_d)
      ROW0: begin
        m_p1_d = pix(win_d, 0);
        m_p2_d = pix(win_d, 1);
        m_p3_d = pix(win_d, 2);
      end
      ROW1: begin
        m_p1_d = pix(win_d, 3);
        m_p2_d = pix(win_d, 4);
        m_p3_d = pix(win_d, 5);
      end
      ROW2: begin
        m_p1_d = pix(win_d, 6);
        m_p2_d = pix(win_d, 7);
        m_p3_d = pix(win_d, 8);
      end
      FINAL: begin
        m_p1_d = rm0_d;
        m_p2_d = rm1_d;
        m_p3_d = rm2_d;
      end
      default: begin
        m_p1_d = '0;
        m_p2_d = '0;
        m_p3_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      win_q       <= '0;
      rm0_q       <= '0;
      rm1_q       <= '0;
      rm2_q       <= '0;
      out_med_q   <= '0;
      win_cnt_q   <= '0;
      m_p1_q      <= '0;
      m_p2_q      <= '0;
      m_p3_q      <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      rm0_q       <= rm0_d;
      rm1_q       <= rm1_d;
      rm2_q       <= rm2_d;
      out_med_q   <= out_med_d;
      win_cnt_q   <= win_cnt_d;
      m_p1_q      <= m_p1_d;
      m_p2_q      <= m_p2_d;
      m_p3_q      <= m_p3_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_med   = out_med_q;
  assign win_cnt   = win_cnt_q;
  assign m_p1      = m_p1_q;
  assign m_p2      = m_p2_q;
  assign m_p3      = m_p3_q;

endmodule
